// File: rtl/command_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : command_dispatcher
// Purpose  : Decodes changes of a host command register into step requests,
//            a memory-clear request and halt/abort pulses. In pulse mode
//            (HANDSHAKE=0) every request is a one-cycle strobe. In handshake
//            mode (HANDSHAKE=1) a request is held until acknowledged or until
//            its wait counter expires, and only one request may be pending.
//
// Ports    : clk                    - single clock, rising edge
//            reset                  - synchronous, active-high
//            command                - command code from host register
//            go[NUM_CH]             - per-channel step request
//            go_ack[NUM_CH]         - per-channel acknowledge
//            request_clear_mem      - memory clear request
//            request_clear_mem_ack  - memory clear acknowledge
//            test_halt              - one-cycle halt pulse
//            test_abort             - one-cycle abort pulse
//            busy                   - a request is pending
//            timeout_err            - sticky acknowledge-timeout flag
//            reject                 - one-cycle pulse, command discarded
//
// Revision : 1.0 - initial release
// ============================================================================
module command_dispatcher #(
    parameter int CMD_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int HANDSHAKE   = 1,
    parameter int TIMEOUT     = 1000,
    parameter int CMD_NULL    = 0,
    parameter int CMD_CLEAR   = 1,
    parameter int CMD_HALT    = 2,
    parameter int CMD_ABORT   = 3,
    parameter int CMD_CH_BASE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CMD_WIDTH-1:0] command,
    output logic [NUM_CH-1:0]    go,
    input  logic [NUM_CH-1:0]    go_ack,
    output logic                 request_clear_mem,
    input  logic                 request_clear_mem_ack,
    output logic                 test_halt,
    output logic                 test_abort,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 reject
);

    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Per-request handshake state; each bit of r_go / r_clr is one FSM.
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PEND = 1'b1;

    logic [CMD_WIDTH-1:0] r_cmd_prev;
    logic [NUM_CH-1:0]    r_go;
    logic                 r_clr;
    logic                 r_halt;
    logic                 r_abort;
    logic                 r_busy;
    logic                 r_terr;
    logic                 r_reject;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_event;
    logic                 w_is_null;
    logic                 w_is_clear;
    logic                 w_is_halt;
    logic                 w_is_abort;
    logic [NUM_CH-1:0]    w_ch_hit;
    logic                 w_is_ch;
    logic                 w_pending;
    logic                 w_ack_hit;

    logic [NUM_CH-1:0]    w_go_nxt;
    logic                 w_clr_nxt;
    logic                 w_halt_nxt;
    logic                 w_abort_nxt;
    logic                 w_busy_nxt;
    logic                 w_terr_nxt;
    logic                 w_reject_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    // ------------------------------------------------------------------
    // Command decode: only a change of the register value is an event.
    // ------------------------------------------------------------------
    assign w_event    = (command != r_cmd_prev);
    assign w_is_null  = (command == CMD_WIDTH'(CMD_NULL));
    assign w_is_clear = (command == CMD_WIDTH'(CMD_CLEAR));
    assign w_is_halt  = (command == CMD_WIDTH'(CMD_HALT));
    assign w_is_abort = (command == CMD_WIDTH'(CMD_ABORT));

    always_comb begin
        w_ch_hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (command == CMD_WIDTH'(CMD_CH_BASE + k)) begin
                w_ch_hit[k] = 1'b1;
            end
        end
    end

    assign w_is_ch   = |w_ch_hit;
    assign w_pending = (|r_go) | r_clr;
    // Acks on lines whose request is low are masked out here.
    assign w_ack_hit = (|(r_go & go_ack)) | (r_clr & request_clear_mem_ack);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_go_nxt     = r_go;
        w_clr_nxt    = r_clr;
        w_cnt_nxt    = r_cnt;
        w_terr_nxt   = r_terr;
        w_halt_nxt   = 1'b0;
        w_abort_nxt  = 1'b0;
        w_reject_nxt = 1'b0;

        if (HANDSHAKE == 0) begin
            // Pulse mode: requests never persist beyond one cycle.
            w_go_nxt  = '0;
            w_clr_nxt = c_IDLE;
            w_cnt_nxt = '0;
        end else if (w_pending) begin
            // Ack is checked before the limit so an ack on the last wait
            // cycle completes normally without flagging a timeout.
            if (w_ack_hit) begin
                w_go_nxt  = '0;
                w_clr_nxt = c_IDLE;
                w_cnt_nxt = '0;
            end else if (r_cnt == c_CNT_LAST) begin
                w_go_nxt   = '0;
                w_clr_nxt  = c_IDLE;
                w_cnt_nxt  = '0;
                w_terr_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end

        if (w_event) begin
            if (w_is_halt) begin
                w_halt_nxt = 1'b1;
            end else if (w_is_abort) begin
                w_abort_nxt = 1'b1;
                if (HANDSHAKE != 0) begin
                    // Abort cancels everything, including a timeout that
                    // would have expired in this same cycle.
                    w_go_nxt   = '0;
                    w_clr_nxt  = c_IDLE;
                    w_cnt_nxt  = '0;
                    w_terr_nxt = r_terr;
                end
            end else if (w_is_clear) begin
                if (r_busy) begin
                    w_reject_nxt = 1'b1;
                end else begin
                    w_abort_nxt = 1'b1;
                    w_terr_nxt  = 1'b0;
                    w_clr_nxt   = c_PEND;
                    w_cnt_nxt   = '0;
                end
            end else if (w_is_ch) begin
                if (r_busy) begin
                    w_reject_nxt = 1'b1;
                end else begin
                    w_go_nxt  = w_ch_hit;
                    w_cnt_nxt = '0;
                end
            end else if (!w_is_null) begin
                w_reject_nxt = 1'b1;
            end
        end

        w_busy_nxt = (HANDSHAKE != 0) ? ((|w_go_nxt) | w_clr_nxt) : 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_prev <= CMD_WIDTH'(CMD_NULL);
            r_go       <= '0;
            r_clr      <= c_IDLE;
            r_halt     <= 1'b0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
            r_reject   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_cmd_prev <= command;
            r_go       <= w_go_nxt;
            r_clr      <= w_clr_nxt;
            r_halt     <= w_halt_nxt;
            r_abort    <= w_abort_nxt;
            r_busy     <= w_busy_nxt;
            r_terr     <= w_terr_nxt;
            r_reject   <= w_reject_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign go                = r_go;
    assign request_clear_mem = r_clr;
    assign test_halt         = r_halt;
    assign test_abort        = r_abort;
    assign busy              = r_busy;
    assign timeout_err       = r_terr;
    assign reject            = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_command_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_command_dispatcher
// Purpose  : Self-checking bench for command_dispatcher. Two instances run on
//            the same stimulus: one in handshake mode with a short timeout,
//            one in pulse mode. Outputs are compared every cycle against a
//            reference model that tracks the pending request as an index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_command_dispatcher;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] command;
    logic [3:0] go_ack;
    logic       clr_ack;

    logic [3:0] go1, go0;
    logic       clr1, halt1, abort1, busy1, terr1, rej1;
    logic       clr0, halt0, abort0, busy0, terr0, rej0;

    always #5 clk = ~clk;

    command_dispatcher #(.CMD_WIDTH(8), .NUM_CH(NUM_CH), .HANDSHAKE(1), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .reset(reset), .command(command),
        .go(go1), .go_ack(go_ack),
        .request_clear_mem(clr1), .request_clear_mem_ack(clr_ack),
        .test_halt(halt1), .test_abort(abort1), .busy(busy1),
        .timeout_err(terr1), .reject(rej1)
    );

    command_dispatcher #(.CMD_WIDTH(8), .NUM_CH(NUM_CH), .HANDSHAKE(0), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .reset(reset), .command(command),
        .go(go0), .go_ack(go_ack),
        .request_clear_mem(clr0), .request_clear_mem_ack(clr_ack),
        .test_halt(halt0), .test_abort(abort0), .busy(busy0),
        .timeout_err(terr0), .reject(rej0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_pend: -1 none, 0..NUM_CH-1 channel, NUM_CH memory clear.
    int   m_prev = 0;
    int   m_pend = -1;
    int   m_age  = 0;
    bit   m_err  = 1'b0;
    logic [3:0] e1_go = '0, e0_go = '0;
    logic e1_clr = 0, e1_halt = 0, e1_abort = 0, e1_busy = 0, e1_terr = 0, e1_rej = 0;
    logic e0_clr = 0, e0_halt = 0, e0_abort = 0, e0_rej = 0;

    task automatic model_step(input logic [7:0] c, input logic [3:0] a, input logic ca, input logic r);
        int code;
        int nxt;
        bit ev;
        bit busy_now;
        bit acked;
        bit new_err;
        e1_halt = 0; e1_abort = 0; e1_rej = 0;
        e0_go = '0; e0_clr = 0; e0_halt = 0; e0_abort = 0; e0_rej = 0;
        if (r) begin
            m_prev = 0; m_pend = -1; m_age = 0; m_err = 0;
            e1_go = '0; e1_clr = 0; e1_busy = 0; e1_terr = 0;
            return;
        end
        code     = int'(c);
        ev       = (code != m_prev);
        m_prev   = code;
        busy_now = (m_pend >= 0);
        nxt      = m_pend;
        new_err  = m_err;
        if (m_pend >= 0) begin
            acked = (m_pend == NUM_CH) ? ca : a[m_pend];
            if (acked) nxt = -1;
            else if (m_age == TIMEOUT - 1) begin nxt = -1; new_err = 1; end
            else m_age++;
        end
        if (ev) begin
            if (code == 2) begin
                e1_halt = 1; e0_halt = 1;
            end else if (code == 3) begin
                e1_abort = 1; e0_abort = 1; nxt = -1; new_err = m_err;
            end else if (code == 1) begin
                e0_clr = 1; e0_abort = 1;
                if (busy_now) e1_rej = 1;
                else begin e1_abort = 1; new_err = 0; nxt = NUM_CH; m_age = 0; end
            end else if (code >= 4 && code < 4 + NUM_CH) begin
                e0_go = 4'(1 << (code - 4));
                if (busy_now) e1_rej = 1;
                else begin nxt = code - 4; m_age = 0; end
            end else if (code != 0) begin
                e1_rej = 1; e0_rej = 1;
            end
        end
        m_pend  = nxt;
        m_err   = new_err;
        e1_go   = (m_pend >= 0 && m_pend < NUM_CH) ? 4'(1 << m_pend) : 4'b0;
        e1_clr  = (m_pend == NUM_CH);
        e1_busy = (m_pend >= 0);
        e1_terr = m_err;
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic [7:0] c, input logic [3:0] a, input logic ca, input logic r);
        command = c; go_ack = a; clr_ack = ca; reset = r;
        model_step(c, a, ca, r);
        @(posedge clk);
        #1;
        check("hs1_go",    32'(go1),    32'(e1_go));
        check("hs1_clr",   32'(clr1),   32'(e1_clr));
        check("hs1_halt",  32'(halt1),  32'(e1_halt));
        check("hs1_abort", 32'(abort1), 32'(e1_abort));
        check("hs1_busy",  32'(busy1),  32'(e1_busy));
        check("hs1_terr",  32'(terr1),  32'(e1_terr));
        check("hs1_rej",   32'(rej1),   32'(e1_rej));
        check("hs0_go",    32'(go0),    32'(e0_go));
        check("hs0_clr",   32'(clr0),   32'(e0_clr));
        check("hs0_halt",  32'(halt0),  32'(e0_halt));
        check("hs0_abort", 32'(abort0), 32'(e0_abort));
        check("hs0_busy",  32'(busy0),  32'd0);
        check("hs0_terr",  32'(terr0),  32'd0);
        check("hs0_rej",   32'(rej0),   32'(e0_rej));
    endtask

    initial begin
        int cnt;
        logic [7:0] c;
        logic [3:0] a;
        int sel;

        reset = 1'b1; command = '0; go_ack = '0; clr_ack = 1'b0;
        step(8'd0, 4'd0, 1'b0, 1'b1);
        step(8'd0, 4'd0, 1'b0, 1'b1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_go",   32'(go1),   32'd0);
        repeat (3) step(8'd0, 4'd0, 1'b0, 1'b0);

        // Pulse mode strobe on 0->5, nothing while held
        step(8'd5, 4'd0, 1'b0, 1'b0);
        check("p0_go5",  32'(go0), 32'h2);
        step(8'd5, 4'b0010, 1'b0, 1'b0);
        check("p0_hold", 32'(go0), 32'h0);
        step(8'd0, 4'd0, 1'b0, 1'b0);

        // Handshake completes on ack: go[0] high four cycles
        step(8'd4, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("ack_hold", 32'(go1), 32'h1);
            step(8'd4, 4'd0, 1'b0, 1'b0);
        end
        check("ack_last", 32'(go1), 32'h1);
        step(8'd4, 4'b0001, 1'b0, 1'b0);
        check("ack_drop", 32'(go1), 32'h0);
        check("ack_terr", 32'(terr1), 32'd0);

        // Timeout on channel 2, then clear
        step(8'd0, 4'd0, 1'b0, 1'b0);
        step(8'd6, 4'd0, 1'b0, 1'b0);
        cnt = 0;
        while (go1[2] && cnt < 20) begin
            cnt++;
            step(8'd6, 4'd0, 1'b0, 1'b0);
        end
        check("to_len",  32'(cnt),   32'd8);
        check("to_terr", 32'(terr1), 32'd1);
        step(8'd1, 4'd0, 1'b0, 1'b0);
        check("clr_abort", 32'(abort1), 32'd1);
        check("clr_req",   32'(clr1),   32'd1);
        check("clr_terr",  32'(terr1),  32'd0);
        step(8'd1, 4'd0, 1'b1, 1'b0);
        check("clr_ack", 32'(clr1), 32'd0);

        // Reject while busy, then abort
        step(8'd0, 4'd0, 1'b0, 1'b0);
        step(8'd4, 4'd0, 1'b0, 1'b0);
        step(8'd5, 4'd0, 1'b0, 1'b0);
        check("busy_rej", 32'(rej1), 32'd1);
        check("busy_go",  32'(go1),  32'h1);
        step(8'd3, 4'd0, 1'b0, 1'b0);
        check("abt_pulse", 32'(abort1), 32'd1);
        check("abt_go",    32'(go1),    32'h0);
        check("abt_busy",  32'(busy1),  32'd0);

        // Halt leaves pending request, invalid code only rejects
        step(8'd0, 4'd0, 1'b0, 1'b0);
        step(8'd5, 4'd0, 1'b0, 1'b0);
        step(8'd2, 4'd0, 1'b0, 1'b0);
        check("halt_pulse", 32'(halt1), 32'd1);
        check("halt_go",    32'(go1),   32'h2);
        step(8'hFF, 4'd0, 1'b0, 1'b0);
        check("inv_rej",  32'(rej1),  32'd1);
        check("inv_go",   32'(go1),   32'h2);
        check("inv_halt", 32'(halt1), 32'd0);
        step(8'd3, 4'd0, 1'b0, 1'b0);

        // Reset mid-handshake with command held
        step(8'd0, 4'd0, 1'b0, 1'b0);
        step(8'd7, 4'd0, 1'b0, 1'b0);
        step(8'd7, 4'd0, 1'b0, 1'b0);
        step(8'd7, 4'd0, 1'b0, 1'b1);
        check("rst_mid_go",   32'(go1),   32'h0);
        check("rst_mid_busy", 32'(busy1), 32'd0);
        step(8'd7, 4'd0, 1'b0, 1'b0);
        check("rst_rel_go", 32'(go1), 32'h8);

        // Randomized traffic
        c = 8'd7;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                sel = int'($urandom_range(0, 19));
                if (sel < 10)       c = 8'(sel);
                else if (sel == 10) c = 8'hFF;
                else if (sel == 11) c = 8'($urandom_range(0, 255));
                else                c = 8'($urandom_range(4, 7));
            end
            for (int k = 0; k < 4; k++) a[k] = ($urandom_range(0, 4) == 0);
            step(c, a, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
